step_range_counter: RTL and testbench

Parametrised successor to the single-step stop-at-end counter used by the layer sequencers. It counts from a loaded start value toward an end value by a programmable step, and either stops or wraps at the end, selected per load. It also reports busy/done status and a one-cycle wrap pulse, so address generators and loop-nest controllers can chain counters without extra glue.

---
 rtl/step_range_counter.sv | 147 ++++++++++++++
 tb/tb_step_range_counter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/step_range_counter.sv
// Step/range counter: counts from a loaded start toward an end by step_i, stopping or wrapping.
// Optional down counting is enabled by defining STEP_RANGE_COUNTER_DOWN_EN.
module step_range_counter #(
  parameter int Bits     = 8,
  parameter int StepBits = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic                en_i,
  input  logic                wrap_i,
  input  logic                dir_i,
  input  logic [Bits-1:0]     start_val_i,
  input  logic [Bits-1:0]     end_val_i,
  input  logic [StepBits-1:0] step_i,
  output logic [Bits-1:0]     count_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                wrap_o
);

  // state   | meaning
  // ST_IDLE | not armed since reset, count held at 0
  // ST_RUN  | armed, stepping on en_i
  // ST_DONE | stop mode reached end, waiting for load
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  if (Bits <= 0 || StepBits <= 0 || StepBits > Bits) begin : g_param_check
    $error("step_range_counter: illegal Bits/StepBits");
  end

  state_e          state_q, state_d;
  logic [Bits-1:0] count_q, count_d;
  logic [Bits-1:0] start_q, start_d;
  logic [Bits-1:0] end_q, end_d;
  logic            mode_q, mode_d;
  logic            wrap_q, wrap_d;

  logic [Bits:0]   step_ext;
  logic [Bits:0]   cand_up;
  logic            hit_up;
  logic            hit;
  logic [Bits-1:0] next_count;

  assign step_ext = {{(Bits + 1 - StepBits){1'b0}}, step_i};
  // Extra bit keeps the sum from wrapping past the top of the range.
  assign cand_up  = {1'b0, count_q} + step_ext;
  assign hit_up   = cand_up >= {1'b0, end_q};

`ifdef STEP_RANGE_COUNTER_DOWN_EN
  logic            dir_q, dir_d;
  logic [Bits:0]   floor_dn;
  logic            hit_dn;
  logic [Bits-1:0] count_dn;

  assign floor_dn   = {1'b0, end_q} + step_ext;
  assign hit_dn     = {1'b0, count_q} < floor_dn;
  assign count_dn   = count_q - step_ext[Bits-1:0];
  assign hit        = dir_q ? hit_dn : hit_up;
  assign next_count = dir_q ? count_dn : cand_up[Bits-1:0];
`else
  logic unused_dir;
  assign unused_dir = dir_i;
  assign hit        = hit_up;
  assign next_count = cand_up[Bits-1:0];
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    start_d = start_q;
    end_d   = end_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
`ifdef STEP_RANGE_COUNTER_DOWN_EN
    dir_d   = dir_q;
`endif
    if (load_i) begin
      start_d = start_val_i;
      end_d   = end_val_i;
      mode_d  = wrap_i;
      count_d = start_val_i;
`ifdef STEP_RANGE_COUNTER_DOWN_EN
      dir_d   = dir_i;
`endif
      state_d = (start_val_i == end_val_i && !wrap_i) ? ST_DONE : ST_RUN;
    end else if (state_q == ST_RUN && en_i && step_i != '0) begin
      if (count_q == end_q) begin
        if (mode_q) begin
          count_d = start_q;
          wrap_d  = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end else if (hit) begin
        // Clamp; in wrap mode the following enabled cycle returns to start.
        count_d = end_q;
        if (!mode_q) state_d = ST_DONE;
      end else begin
        count_d = next_count;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      start_q <= '0;
      end_q   <= '0;
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef STEP_RANGE_COUNTER_DOWN_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      start_q <= start_d;
      end_q   <= end_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
`ifdef STEP_RANGE_COUNTER_DOWN_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign count_o = count_q;
  assign busy_o  = (state_q == ST_RUN);
  assign done_o  = (state_q == ST_DONE);
  assign wrap_o  = wrap_q;

`ifndef SYNTHESIS
  logic range_bad;
`ifdef STEP_RANGE_COUNTER_DOWN_EN
  assign range_bad = dir_i ? (end_val_i > start_val_i) : (end_val_i < start_val_i);
`else
  assign range_bad = end_val_i < start_val_i;
`endif
  always @(posedge clk_i) begin
    if (rst_ni && load_i && range_bad)
      $error("step_range_counter: end value on wrong side of start for direction");
  end
`endif

endmodule

// File: tb/tb_step_range_counter.sv
// Scoreboard bench for step_range_counter: expected records queued with stimulus, compared to outputs.
`timescale 1ns/1ps
module tb_step_range_counter;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       load_i = 1'b0, en_i = 1'b0, wrap_i = 1'b0, dir_i = 1'b0;
  logic [7:0] start_val_i = '0, end_val_i = '0;
  logic [3:0] step_i = '0;
  logic [7:0] count_o;
  logic       busy_o, done_o, wrap_o;

  typedef logic [10:0] rec_t;  // {count, busy, done, wrap}
  rec_t sb[$];
  rec_t obs[$];
  int   checks = 0;
  int   errors = 0;

  step_range_counter #(.Bits(8), .StepBits(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_i(load_i), .en_i(en_i), .wrap_i(wrap_i),
    .dir_i(dir_i), .start_val_i(start_val_i), .end_val_i(end_val_i), .step_i(step_i),
    .count_o(count_o), .busy_o(busy_o), .done_o(done_o), .wrap_o(wrap_o)
  );

  always #5 clk_i = ~clk_i;

  // Drives one cycle, queues the expected record, clocks, and records what the DUT shows.
  task automatic cyc(input logic ld, input logic en, input logic wr, input logic dr,
                     input logic [7:0] st, input logic [7:0] ed, input logic [3:0] stp,
                     input logic [7:0] ecnt, input logic eb, input logic ed_o, input logic ew);
    load_i = ld; en_i = en; wrap_i = wr; dir_i = dr;
    start_val_i = st; end_val_i = ed; step_i = stp;
    sb.push_back({ecnt, eb, ed_o, ew});
    @(posedge clk_i); #1;
    obs.push_back({count_o, busy_o, done_o, wrap_o});
    load_i = 1'b0; en_i = 1'b0;
  endtask

  task automatic test_reset();
    rec_t e, o;
    #2 rst_ni = 1'b0;
    en_i = 1'b1;
    #1;
    sb.push_back(11'h0);
    obs.push_back({count_o, busy_o, done_o, wrap_o});
    @(negedge clk_i) rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 8'h22, 4'd1, 8'h22, 1'b0, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset: got cnt=%h b/d/w=%b required cnt=%h b/d/w=%b", o[10:3], o[2:0], e[10:3], e[2:0]);
      end
    end
  endtask

  task automatic test_stop();
    rec_t e, o;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h1A, 4'd3, 8'h10, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd3, 8'h13, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd3, 8'h16, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd3, 8'h19, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd3, 8'h1A, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd3, 8'h1A, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd3, 8'h1A, 1'b0, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stop_mode: got cnt=%h b/d/w=%b required cnt=%h b/d/w=%b", o[10:3], o[2:0], e[10:3], e[2:0]);
      end
    end
  endtask

  task automatic test_clamp_top();
    rec_t e, o;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 4'd15, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 18; k++)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd15,
          (k <= 16) ? 8'(15 * k) : 8'hFF, k <= 16, k > 16, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL clamp_top: got cnt=%h b/d/w=%b required cnt=%h b/d/w=%b", o[10:3], o[2:0], e[10:3], e[2:0]);
      end
    end
  endtask

  task automatic test_wrap();
    rec_t e, o;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 8'h08, 4'd2, 8'h05, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd2, 8'h07, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd2, 8'h08, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd2, 8'h05, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd2, 8'h07, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd2, 8'h07, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd2, 8'h08, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd2, 8'h08, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd2, 8'h05, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd2, 8'h05, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd2, 8'h07, 1'b1, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap_mode: got cnt=%h b/d/w=%b required cnt=%h b/d/w=%b", o[10:3], o[2:0], e[10:3], e[2:0]);
      end
    end
  endtask

  // Continues from test_wrap, which leaves the counter in RUN at 7.
  task automatic test_load_priority();
    rec_t e, o;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h05, 8'h08, 4'd2, 8'h05, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd2, 8'h07, 1'b1, 1'b0, 1'b0);
    rst_ni = 1'b0;
    #1;
    sb.push_back(11'h0);
    obs.push_back({count_o, busy_o, done_o, wrap_o});
    @(negedge clk_i) rst_ni = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL load_priority: got cnt=%h b/d/w=%b required cnt=%h b/d/w=%b", o[10:3], o[2:0], e[10:3], e[2:0]);
      end
    end
  endtask

  task automatic test_down();
    rec_t e, o;
`ifdef STEP_RANGE_COUNTER_DOWN_EN
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 8'h01, 4'd3, 8'h08, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd3, 8'h05, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd3, 8'h02, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd3, 8'h01, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd3, 8'h01, 1'b0, 1'b1, 1'b0);
`else
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h08, 4'd3, 8'h01, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 4'd3, 8'h04, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 4'd3, 8'h07, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 4'd3, 8'h08, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 4'd3, 8'h08, 1'b0, 1'b1, 1'b0);
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL direction: got cnt=%h b/d/w=%b required cnt=%h b/d/w=%b", o[10:3], o[2:0], e[10:3], e[2:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 8'h06, 4'd1, 8'h03, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h09, 8'h09, 4'd1, 8'h09, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd1, 8'h09, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd1, 8'h09, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 8'h09, 4'd0, 8'h02, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 8'h02, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd7, 8'h09, 1'b0, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back: got cnt=%h b/d/w=%b required cnt=%h b/d/w=%b", o[10:3], o[2:0], e[10:3], e[2:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stop();
    test_clamp_top();
    test_wrap();
    test_load_priority();
    test_down();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
